fifo_param_ctrl: RTL and testbench

//  Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds,

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_mem.sv | 38 +++
 rtl/fifo_param_ctrl.sv | 138 +++++++++++++
 tb/tb_fifo_param_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO: one-hot control states.
package fifo_pkg;

    localparam int STATE_W = 5;

    localparam logic [STATE_W-1:0] ST_RESET  = 5'b00001;
    localparam logic [STATE_W-1:0] ST_INIT   = 5'b00010;
    localparam logic [STATE_W-1:0] ST_IDLE   = 5'b00100;
    localparam logic [STATE_W-1:0] ST_ACTIVE = 5'b01000;
    localparam logic [STATE_W-1:0] ST_ERROR  = 5'b10000;

    typedef enum logic [STATE_W-1:0] {
        S_RESET  = ST_RESET,
        S_INIT   = ST_INIT,
        S_IDLE   = ST_IDLE,
        S_ACTIVE = ST_ACTIVE,
        S_ERROR  = ST_ERROR
    } state_t;

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: one write port, one registered read port.
module fifo_mem #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_vld
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Read port: a same-edge write to rd_addr is not visible, so the oldest word leaves first
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en)
                rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_param_ctrl.sv
// Parametrised synchronous FIFO with programmable thresholds, sticky error flags and control FSM.
module fifo_param_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [ADDR_WIDTH:0]   init_full,
    input  logic [ADDR_WIDTH:0]   init_empty,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic [STATE_W-1:0]    state
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_WIDTH);

    function automatic logic [CNT_W-1:0] clamp_thr(input logic [CNT_W-1:0] t);
        return (t > DEPTH) ? DEPTH : t;
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      thr_full, thr_empty;
    logic                  ovf_q, unf_q;

    logic live, push_ok, pop_ok, ovf_evt, unf_evt;

    assign live    = (state_q == S_IDLE) || (state_q == S_ACTIVE);
    assign pop_ok  = live && pop && (count != '0);
    // A full FIFO still takes a push when a pop frees the slot on the same edge
    assign push_ok = live && push && ((count < DEPTH) || pop_ok);
    assign ovf_evt = live && push && !push_ok;
    assign unf_evt = live && pop && (count == '0);

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_RESET;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RESET:  state_d = S_INIT;
            S_INIT:   state_d = init ? S_INIT : S_IDLE;
            S_IDLE: begin
                if (ovf_evt || unf_evt)
                    state_d = S_ERROR;
                else if (push || pop)
                    state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (ovf_evt || unf_evt)
                    state_d = S_ERROR;
                else if ((count == '0) && !push)
                    state_d = S_IDLE;
            end
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_RESET;
        endcase
        if (init && (state_q != S_RESET))
            state_d = S_INIT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            thr_full  <= DEPTH - CNT_W'(2);
            thr_empty <= CNT_W'(1);
        end else if (state_q == S_INIT) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            thr_full  <= clamp_thr(init_full);
            thr_empty <= clamp_thr(init_empty);
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)
                count <= count + CNT_W'(1);
            else if (pop_ok && !push_ok)
                count <= count - CNT_W'(1);
            if (ovf_evt)
                ovf_q <= 1'b1;
            if (unf_evt)
                unf_q <= 1'b1;
        end
    end

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_out),
        .rd_vld  (valid_out)
    );

    assign full         = (count == DEPTH);
    assign empty        = (count == '0);
    assign almost_full  = (count >= thr_full);
    assign almost_empty = (count <= thr_empty);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign fill_count   = count;
    assign state        = state_q;

endmodule

// File: tb/tb_fifo_param_ctrl.sv
// Directed bench for fifo_param_ctrl with a data scoreboard queue.
module tb_fifo_param_ctrl;

    logic        clk = 1'b0;
    logic        reset, init, push, pop;
    logic [3:0]  init_full, init_empty;
    logic [11:0] data_in, data_out;
    logic        valid_out, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0]  fill_count;
    logic [4:0]  state;

    int checks = 0;
    int errors = 0;
    logic [11:0] sb[$];
    logic live = 1'b0;

    fifo_param_ctrl #(.DATA_WIDTH(12), .ADDR_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .init(init), .init_full(init_full), .init_empty(init_empty),
        .push(push), .pop(pop), .data_in(data_in), .data_out(data_out), .valid_out(valid_out),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow), .fill_count(fill_count), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle; acceptance is predicted from the scoreboard occupancy
    task automatic cyc(input logic p, input logic q, input logic [11:0] d);
        logic pa, qa;
        logic [11:0] e;
        qa = live && q && (sb.size() > 0);
        pa = live && p && ((sb.size() < 8) || qa);
        push = p; pop = q; data_in = d;
        tick();
        push = 1'b0; pop = 1'b0;
        if (qa) begin
            e = sb.pop_front();
            chk("data_out", 32'(data_out), 32'(e));
        end
        chk("valid_out", 32'(valid_out), 32'(qa));
        if (pa) sb.push_back(d);
        chk("fill_count", 32'(fill_count), 32'(sb.size()));
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; push = 1'b0; pop = 1'b0;
        init_full = 4'd6; init_empty = 4'd1; data_in = '0;

        // 1. reset, init, release
        tick();
        chk("rst_state", 32'(state), 32'h01);
        chk("rst_count", 32'(fill_count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_aempty", 32'(almost_empty), 1);
        chk("rst_afull", 32'(almost_full), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_dout", 32'(data_out), 0);
        reset = 1'b0; init = 1'b1;
        tick();
        chk("init_state", 32'(state), 32'h02);
        tick();
        chk("init_hold", 32'(state), 32'h02);
        init = 1'b0;
        tick();
        chk("idle_state", 32'(state), 32'h04);
        live = 1'b1;

        // 2. two pushes, two pops
        cyc(1'b1, 1'b0, 12'h00A);
        chk("active_state", 32'(state), 32'h08);
        cyc(1'b1, 1'b0, 12'h00B);
        cyc(1'b0, 1'b1, 12'h000);
        cyc(1'b0, 1'b1, 12'h000);
        chk("t2_empty", 32'(empty), 1);
        cyc(1'b0, 1'b0, 12'h000);
        chk("t2_idle", 32'(state), 32'h04);

        // 3. fill to full, then overflow
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 12'(12'h100 + i));
            chk("t3_afull", 32'(almost_full), 32'(i + 1 >= 6));
            chk("t3_full", 32'(full), 32'(i + 1 == 8));
            chk("t3_aempty", 32'(almost_empty), 32'(i + 1 <= 1));
        end
        cyc(1'b1, 1'b0, 12'hBAD);
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_err", 32'(state), 32'h10);
        live = 1'b0;
        cyc(1'b0, 1'b1, 12'h000);
        chk("t3_err_hold", 32'(state), 32'h10);

        // 4. recover with clamped thresholds, then underflow
        init = 1'b1; init_full = 4'd15; init_empty = 4'd3;
        tick();
        chk("t4_init", 32'(state), 32'h02);
        tick();
        sb.delete();
        chk("t4_ovf_clr", 32'(overflow), 0);
        chk("t4_cnt_clr", 32'(fill_count), 0);
        init = 1'b0;
        tick();
        chk("t4_idle", 32'(state), 32'h04);
        live = 1'b1;
        cyc(1'b0, 1'b1, 12'h000);
        chk("t4_unf", 32'(underflow), 1);
        chk("t4_err", 32'(state), 32'h10);
        live = 1'b0;
        init = 1'b1;
        tick();
        tick();
        chk("t4_unf_clr", 32'(underflow), 0);
        chk("t4_init2", 32'(state), 32'h02);
        chk("t4_empty", 32'(empty), 1);
        init = 1'b0;
        tick();
        live = 1'b1;

        // 5. full FIFO with simultaneous push+pop, wrapping pointers
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 12'(12'h200 + i));
            chk("t5_afull", 32'(almost_full), 32'(i + 1 >= 8));
            chk("t5_aempty", 32'(almost_empty), 32'(i + 1 <= 3));
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 12'(12'h300 + 17 * i));
            chk("t5_full", 32'(full), 1);
            chk("t5_ovf", 32'(overflow), 0);
        end
        chk("t5_active", 32'(state), 32'h08);

        // 6. reset mid-operation
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 12'h000);
        chk("t6_cnt5", 32'(fill_count), 5);
        reset = 1'b1;
        tick();
        sb.delete();
        live = 1'b0;
        chk("t6_cnt", 32'(fill_count), 0);
        chk("t6_empty", 32'(empty), 1);
        chk("t6_valid", 32'(valid_out), 0);
        chk("t6_dout", 32'(data_out), 0);
        chk("t6_state", 32'(state), 32'h01);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
